// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU frame-buffer writer path.
package gpu_pkg;

   localparam int FB_WIDTH  = 320;
   localparam int FB_HEIGHT = 240;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   typedef struct packed {
      logic [8:0]  x;
      logic [7:0]  y;
      logic [23:0] color;
      logic        buf_sel;
   } pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_XFER,
      ST_CLEAR,
      ST_FLUSH
   } wr_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of rasterized pixels between the input handshake
// and the AHB write master.
module pixel_fifo
   import gpu_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push_i,
   input  logic   pop_i,
   input  pixel_t din_i,
   output pixel_t dout_o,
   output logic   full_o,
   output logic   empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   pixel_t        mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign dout_o  = mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            wr_q <= wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_q <= rd_q + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/ahb_pixel_writer.sv
// Pixel FIFO front end plus AHB-Lite single-beat write master; also
// performs the whole-buffer clear fill.
module ahb_pixel_writer
   import gpu_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] FB_BASE    = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [8:0]  pix_x,
   input  logic [7:0]  pix_y,
   input  logic [23:0] pix_color,
   input  logic        pix_buf,
   input  logic        clr_req,
   input  logic        clr_buf,
   input  logic [23:0] clr_color,
   output logic        clr_done,
   output logic        busy,
   output logic [15:0] drop_cnt,
   output logic [31:0] HADDR,
   output logic [31:0] HWDATA,
   output logic        HWRITE,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   input  logic        HREADY
);

   localparam logic [8:0] X_LIM    = 9'(FB_WIDTH);
   localparam logic [7:0] Y_LIM    = 8'(FB_HEIGHT);
   localparam logic [8:0] BUF1_ROW = 9'(FB_HEIGHT);

   // Buffer 1 is stacked below buffer 0, so it is just a row offset.
   function automatic logic [31:0] pix_addr(
      input logic [8:0] x,
      input logic [7:0] y,
      input logic       b
   );
      logic [8:0]  row;
      logic [17:0] off;
      row = {1'b0, y} + (b ? BUF1_ROW : 9'd0);
      off = {1'b0, row, 8'h00} + {3'b000, row, 6'h00} + {9'h000, x};
      return FB_BASE + {12'h000, off, 2'b00};
   endfunction

   wr_state_e   state_q, state_d;
   pixel_t      in_pix, head;
   logic        push, pop, full, empty, hs, in_range;
   logic        issue;
   logic [31:0] iss_addr, iss_data;
   logic        aact_q, dval_q;
   logic [31:0] haddr_q, awdata_q, hwdata_q;
   logic        clr_pend_q, cbuf_q;
   logic [23:0] ccol_q;
   logic [8:0]  cx_q, cx_d;
   logic [7:0]  cy_q, cy_d;
   logic        done_q, done_d;
   logic [15:0] drop_q;
   logic        clr_busy;

   assign clr_busy  = (state_q == ST_CLEAR) | (state_q == ST_FLUSH);
   assign pix_ready = ~full & ~clr_pend_q & ~clr_busy & ~rst;
   assign hs        = pix_valid & pix_ready;
   assign in_range  = (pix_x < X_LIM) & (pix_y < Y_LIM);
   assign push      = hs & in_range;
   assign in_pix    = '{x: pix_x, y: pix_y, color: pix_color,
                        buf_sel: pix_buf};

   pixel_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push),
      .pop_i  (pop),
      .din_i  (in_pix),
      .dout_o (head),
      .full_o (full),
      .empty_o(empty)
   );

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      issue    = 1'b0;
      iss_addr = pix_addr(head.x, head.y, head.buf_sel);
      iss_data = {8'h00, head.color};
      cx_d     = cx_q;
      cy_d     = cy_q;
      done_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               state_d = ST_XFER;
               pop     = HREADY;
               issue   = HREADY;
            end else if (clr_pend_q) begin
               state_d = ST_CLEAR;
               cx_d    = '0;
               cy_d    = '0;
            end
         end
         ST_XFER: begin
            pop   = HREADY & ~empty;
            issue = pop;
            if (empty && !aact_q && (!dval_q || HREADY)) begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            issue    = HREADY;
            iss_addr = pix_addr(cx_q, cy_q, cbuf_q);
            iss_data = {8'h00, ccol_q};
            if (HREADY) begin
               if (cx_q == X_LIM - 9'd1) begin
                  cx_d = '0;
                  if (cy_q == Y_LIM - 8'd1) begin
                     state_d = ST_FLUSH;
                  end else begin
                     cy_d = cy_q + 8'd1;
                  end
               end else begin
                  cx_d = cx_q + 9'd1;
               end
            end
         end
         ST_FLUSH: begin
            if (!aact_q && (!dval_q || HREADY)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         aact_q     <= 1'b0;
         dval_q     <= 1'b0;
         haddr_q    <= '0;
         awdata_q   <= '0;
         hwdata_q   <= '0;
         clr_pend_q <= 1'b0;
         cbuf_q     <= 1'b0;
         ccol_q     <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         done_q     <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         done_q  <= done_d;
         // Address and data phases only advance on HREADY edges.
         if (HREADY) begin
            dval_q <= aact_q;
            aact_q <= issue;
            if (aact_q) begin
               hwdata_q <= awdata_q;
            end
            if (issue) begin
               haddr_q  <= iss_addr;
               awdata_q <= iss_data;
            end
         end
         if (state_q == ST_IDLE && state_d == ST_CLEAR) begin
            clr_pend_q <= 1'b0;
         end else if (clr_req && !clr_pend_q && !clr_busy) begin
            clr_pend_q <= 1'b1;
            cbuf_q     <= clr_buf;
            ccol_q     <= clr_color;
         end
         if (hs && !in_range && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
         end
      end
   end

   assign HADDR    = haddr_q;
   assign HWDATA   = hwdata_q;
   assign HTRANS   = aact_q ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HWRITE   = aact_q;
   assign HSIZE    = HSIZE_WORD;
   assign clr_done = done_q;
   assign drop_cnt = drop_q;
   assign busy     = ~empty | aact_q | dval_q | clr_pend_q |
                     (state_q != ST_IDLE);

endmodule

// File: tb/tb_ahb_pixel_writer.sv
// Randomized scoreboard bench for ahb_pixel_writer: expected AHB beats
// come from a frame-buffer address model and are matched by a monitor.
`timescale 1ns/1ps
module tb_ahb_pixel_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic [8:0]  pix_x = '0;
   logic [7:0]  pix_y = '0;
   logic [23:0] pix_color = '0;
   logic        pix_buf = 1'b0;
   logic        clr_req = 1'b0;
   logic        clr_buf = 1'b0;
   logic [23:0] clr_color = '0;
   logic        clr_done;
   logic        busy;
   logic [15:0] drop_cnt;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic        HWRITE;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HREADY = 1'b1;

   ahb_pixel_writer dut (
      .clk      (clk),
      .rst      (rst),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .pix_x    (pix_x),
      .pix_y    (pix_y),
      .pix_color(pix_color),
      .pix_buf  (pix_buf),
      .clr_req  (clr_req),
      .clr_buf  (clr_buf),
      .clr_color(clr_color),
      .clr_done (clr_done),
      .busy     (busy),
      .drop_cnt (drop_cnt),
      .HADDR    (HADDR),
      .HWDATA   (HWDATA),
      .HWRITE   (HWRITE),
      .HTRANS   (HTRANS),
      .HSIZE    (HSIZE),
      .HREADY   (HREADY)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } beat_t;

   beat_t       exp_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          exp_drop = 0;
   int          hr_mode = 0;
   bit          sb_en = 1'b1;
   bit          clr_window = 1'b0;
   bit          stalled = 1'b0;
   int          nbeats = 0;
   int          cap_idx = -1;
   logic [31:0] cap_addr = '0;
   logic [31:0] last_addr = '0;
   int          done_cnt = 0;
   int          ready_viol = 0;
   bit          dph = 1'b0;
   logic [31:0] dph_data;
   bit          st_a = 1'b0;
   bit          st_d = 1'b0;
   logic [31:0] st_addr, st_data;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] model_addr(int x, int y, bit b);
      int row;
      row = y + (b ? 240 : 0);
      return 32'(4 * (row * 320 + x));
   endfunction

   function automatic void model_accept(int x, int y,
                                        logic [23:0] c, bit b);
      beat_t e;
      if (x < 320 && y < 240) begin
         e.a = model_addr(x, y, b);
         e.d = {8'h00, c};
         exp_q.push_back(e);
      end else begin
         exp_drop++;
      end
   endfunction

   // HREADY: 0 = high, 1 = random, 2 = low
   always @(posedge clk) begin
      #2;
      case (hr_mode)
         1:       HREADY = ($urandom_range(0, 9) < 7);
         2:       HREADY = 1'b0;
         default: HREADY = 1'b1;
      endcase
   end

   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         dph  = 1'b0;
         st_a = 1'b0;
         st_d = 1'b0;
      end else begin
         if (st_a && sb_en) begin
            chk("stall_haddr", HADDR, st_addr);
            chk("stall_htrans", {30'h0, HTRANS}, 32'h2);
         end
         if (st_d && sb_en) chk("stall_hwdata", HWDATA, st_data);
         if (clr_done) done_cnt++;
         if (clr_window && pix_ready && !clr_done) ready_viol++;
         if (dph && HREADY) begin
            if (sb_en) chk("hwdata", HWDATA, dph_data);
            dph = 1'b0;
         end
         if (HTRANS == 2'b10 && HREADY) begin
            nbeats++;
            if (nbeats == cap_idx) cap_addr = HADDR;
            last_addr = HADDR;
            if (sb_en) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", HADDR, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("haddr", HADDR, e.a);
                  chk("ctrl", {28'h0, HWRITE, HSIZE}, 32'hA);
                  dph      = 1'b1;
                  dph_data = e.d;
               end
            end
         end
         st_a    = (HTRANS == 2'b10) && !HREADY;
         st_addr = HADDR;
         st_d    = dph && !HREADY;
         st_data = HWDATA;
      end
   end

   // Called just after a rising edge; returns just after the handshake edge.
   task automatic send(input int x, input int y, input logic [23:0] c,
                       input bit b);
      int w;
      w = 0;
      pix_valid = 1'b1;
      pix_x     = 9'(x);
      pix_y     = 8'(y);
      pix_color = c;
      pix_buf   = b;
      @(negedge clk);
      while (!pix_ready) begin
         w++;
         if (w > 500) begin
            chk("ready_timeout", 32'(pix_ready), 32'h1);
            pix_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      if (w > 0) stalled = 1'b1;
      @(posedge clk);
      model_accept(x, y, c, b);
      #1;
      pix_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0 && !dph) begin
            ok = 1'b1;
            break;
         end
      end
      chk(nm, 32'(ok), 32'h1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, d0;
      bit got;
      beat_t e;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
      chk("rst_hwrite", {31'h0, HWRITE}, 32'h0);
      chk("rst_hsize", {29'h0, HSIZE}, 32'h2);
      chk("rst_ready", {31'h0, pix_ready}, 32'h0);
      chk("rst_done", {31'h0, clr_done}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_drop", {16'h0, drop_cnt}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      send(5, 2, 24'h00FF00, 1'b0);
      @(negedge clk);
      chk("lat_busy0", {31'h0, busy}, 32'h1);
      @(negedge clk);
      chk("lat_htrans", {30'h0, HTRANS}, 32'h2);
      chk("lat_haddr", HADDR, 32'h0000_0A14);
      @(negedge clk);
      chk("lat_hwdata", HWDATA, 32'h0000_FF00);
      chk("lat_idle", {30'h0, HTRANS}, 32'h0);
      chk("lat_busy2", {31'h0, busy}, 32'h1);
      @(negedge clk);
      chk("lat_busy3", {31'h0, busy}, 32'h0);
      @(posedge clk);
      #1;

      send(319, 239, 24'h123456, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("corner_haddr", HADDR, 32'h0009_5FFC);
      @(posedge clk);
      #1;
      wait_idle("idle_corner");

      stalled = 1'b0;
      fork
         begin
            repeat (3) @(posedge clk);
            hr_mode = 2;
            repeat (10) @(posedge clk);
            hr_mode = 0;
         end
      join_none
      for (int i = 0; i < 12; i++) begin
         send($urandom_range(0, 319), $urandom_range(0, 239),
              24'($urandom), 1'($urandom));
      end
      chk("full_backpressure", {31'h0, stalled}, 32'h1);
      wait_idle("idle_burst");

      send(320, 10, 24'hABCDEF, 1'b0);
      send(10, 240, 24'hABCDEF, 1'b1);
      repeat (4) @(negedge clk);
      chk("drop_cnt2", {16'h0, drop_cnt}, 32'h2);
      chk("drop_busy", {31'h0, busy}, 32'h0);
      @(posedge clk);
      #1;

      hr_mode = 1;
      for (int i = 0; i < 150; i++) begin
         send($urandom_range(0, 335), $urandom_range(0, 250),
              24'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      hr_mode = 0;
      wait_idle("idle_random");
      chk("drop_random", {16'h0, drop_cnt}, 32'(exp_drop));

      hr_mode = 2;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         send(i * 7, i + 1, 24'h0A0B00 + 24'(i), 1'b0);
      end
      d0 = done_cnt;
      ready_viol = 0;
      clr_req   = 1'b1;
      clr_buf   = 1'b1;
      clr_color = 24'hFFFFFF;
      cap_idx   = nbeats + 4;
      for (int y = 0; y < 240; y++) begin
         for (int x = 0; x < 320; x++) begin
            e.a = model_addr(x, y, 1'b1);
            e.d = 32'h00FF_FFFF;
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      clr_req    = 1'b0;
      clr_window = 1'b1;
      hr_mode    = 0;
      repeat (100) @(posedge clk);
      #1;
      clr_req   = 1'b1;
      clr_buf   = 1'b0;
      clr_color = 24'h123456;
      @(posedge clk);
      #1;
      clr_req = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 80000; i++) begin
         @(negedge clk);
         if (clr_done) begin
            got = 1'b1;
            break;
         end
      end
      chk("clr_done_seen", {31'h0, got}, 32'h1);
      clr_window = 1'b0;
      repeat (4) @(negedge clk);
      chk("clr_done_once", 32'(done_cnt), 32'(d0 + 1));
      chk("clr_first_addr", cap_addr, 32'h0004_B000);
      chk("clr_last_addr", last_addr, 32'h0009_5FFC);
      chk("clr_q_empty", 32'(exp_q.size()), 32'h0);
      chk("clr_ready_low", 32'(ready_viol), 32'h0);
      chk("clr_busy_end", {31'h0, busy}, 32'h0);
      chk("clr_ready_end", {31'h0, pix_ready}, 32'h1);
      @(posedge clk);
      #1;

      sb_en = 1'b0;
      b0 = nbeats;
      clr_req   = 1'b1;
      clr_buf   = 1'b0;
      clr_color = 24'h00AA55;
      @(posedge clk);
      #1;
      clr_req = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk);
         if (nbeats >= b0 + 1000) begin
            got = 1'b1;
            break;
         end
      end
      chk("clr2_reached", {31'h0, got}, 32'h1);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_drop = 0;
      d0 = done_cnt;
      @(negedge clk);
      chk("mid_rst_htrans", {30'h0, HTRANS}, 32'h0);
      chk("mid_rst_busy", {31'h0, busy}, 32'h0);
      chk("mid_rst_drop", {16'h0, drop_cnt}, 32'h0);
      repeat (20) @(negedge clk);
      chk("mid_rst_nodone", 32'(done_cnt), 32'(d0));
      chk("mid_rst_quiet", {30'h0, HTRANS}, 32'h0);
      sb_en = 1'b1;
      @(posedge clk);
      #1;
      send(100, 50, 24'h55AA33, 1'b1);
      wait_idle("idle_post_rst");
      chk("final_q_empty", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
